// File: rtl/gpio_resp_pkg.sv
// rtl/gpio_resp_pkg.sv - shared register offsets and FSM state encoding for gpio_responder
//   Contents: word offsets OFF_DOUT/OFF_DIR/OFF_DIN/OFF_IRQ (addr[3:2]),
//             state_t with ST_IDLE/ST_RESP.
package gpio_resp_pkg;

    localparam logic [1:0] OFF_DOUT = 2'd0;
    localparam logic [1:0] OFF_DIR  = 2'd1;
    localparam logic [1:0] OFF_DIN  = 2'd2;
    localparam logic [1:0] OFF_IRQ  = 2'd3;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RESP = 1'b1;

endpackage

// File: rtl/gpio_sync.sv
// rtl/gpio_sync.sv - WIDTH-wide, STAGES-deep flop synchronizer for asynchronous pad inputs
//   Ports: clk, reset (sync, active-high), d (async in), q (synchronized out).
//   All stages reset to 0.
module gpio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/gpio_responder.sv
// rtl/gpio_responder.sv - bus responder implementing a GPIO bank in a 16-byte window
//   Ports: clk, reset (sync, active-high); bus side valid/addr/wdata/wstrb in,
//          ready/rdata out; pad side gpio_in in, gpio_out/gpio_oe out;
//          irq out only when GPIO_RESP_IRQ_EN is defined.
//   Map (addr[3:2]): 0 DATA_OUT rw, 1 DIR rw, 2 DATA_IN ro, 3 IRQ_STATUS w1c
//          (reads 0 and ignores writes unless GPIO_RESP_IRQ_EN).
//   Macro: GPIO_RESP_IRQ_EN enables rising-edge capture and the irq output.
module gpio_responder
    import gpio_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int          WIDTH       = 8,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic             wstrb,
    output logic             ready,
    output logic [31:0]      rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe
`ifdef GPIO_RESP_IRQ_EN
    ,
    output logic             irq
`endif
);

    state_t           state;
    logic             hit;
    logic [1:0]       off;
    logic             accept;
    logic [WIDTH-1:0] din_sync;
    logic [31:0]      rd_val;

    // Byte lanes and the upper write-data bits carry no meaning here.
    logic             unused_bits;
    assign unused_bits = ^{addr[1:0], wdata};

    assign hit    = (addr[31:4] == BASE_ADDR[31:4]);
    assign off    = addr[3:2];
    // valid is only looked at in IDLE, so a held request cannot retrigger during RESP.
    assign accept = (state == ST_IDLE) && valid && hit;

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (gpio_in),
        .q     (din_sync)
    );

`ifdef GPIO_RESP_IRQ_EN
    logic [WIDTH-1:0] din_prev;
    logic [WIDTH-1:0] irq_status;
    logic [WIDTH-1:0] irq_clr;
    logic [WIDTH-1:0] irq_next;
    logic             irq_q;

    always_comb begin
        irq_clr = '0;
        if (accept && wstrb && (off == OFF_IRQ)) begin
            irq_clr = wdata[WIDTH-1:0];
        end
        // Rising edge is OR-ed after the clear so a same-cycle set survives.
        irq_next = (irq_status & ~irq_clr) | (din_sync & ~din_prev);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            din_prev   <= '0;
            irq_status <= '0;
            irq_q      <= 1'b0;
        end else begin
            din_prev   <= din_sync;
            irq_status <= irq_next;
            // Registered from the next-state value so irq tracks IRQ_STATUS without lag.
            irq_q      <= |irq_next;
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_DOUT: rd_val[WIDTH-1:0] = gpio_out;
            OFF_DIR:  rd_val[WIDTH-1:0] = gpio_oe;
            OFF_DIN:  rd_val[WIDTH-1:0] = din_sync;
`ifdef GPIO_RESP_IRQ_EN
            OFF_IRQ:  rd_val[WIDTH-1:0] = irq_status;
`endif
            default:  rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ready    <= 1'b0;
            rdata    <= '0;
            gpio_out <= '0;
            gpio_oe  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_RESP;
                        ready <= 1'b1;
                        rdata <= wstrb ? 32'h0 : rd_val;
                        if (wstrb) begin
                            case (off)
                                OFF_DOUT: gpio_out <= wdata[WIDTH-1:0];
                                OFF_DIR:  gpio_oe  <= wdata[WIDTH-1:0];
                                default:  ;
                            endcase
                        end
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    ready <= 1'b0;
                    rdata <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b0;
                    rdata <= '0;
                end
            endcase
        end
    end

endmodule
